send_seq: RTL and testbench
===========================

Name: send_seq

Overview:
- Parametrised successor to the single-strip pixel address sender. On a trigger it walks a pixel-address window once per enabled strip channel and presents each address to the WS2812 bit encoder over a valid/ready handshake.
- It adds generic address width, a channel count with an enable mask, a reverse walk direction and an abort input.
- It sits between the UART command decoder (which supplies start, length, mask and trigger) and the pixel RAM read port and encoder.

Parameters:
- ADDR_W, 8, width of the pixel address and of the length.
- CHANNELS, 4, number of strip channels (1..16).
- CH_W, $clog2(CHANNELS) with a minimum of 1, derived local width of the channel index.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start_addr  in  ADDR_W  first pixel address, sampled on an accepted trigger.
- length  in  ADDR_W  pixels per channel; 0 means an empty frame.
- chan_mask  in  CHANNELS  bit c enables channel c; sampled on an accepted trigger.
- reverse  in  1  when 1, walk start_addr, start_addr-1, ...; sampled on an accepted trigger.
- trigger  in  1  one-cycle start request.
- abort  in  1  synchronous cancel.
- addr  out  ADDR_W  current pixel address.
- chan  out  CH_W  current channel index.
- valid  out  1  addr/chan are valid.
- ready  in  1  consumer accepts addr/chan.
- last  out  1  qualifies the final beat of the frame.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; addr=0, chan=0, valid=0, last=0, busy=0, done=0; internal counters cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - trigger=1 at rising edge t latches start_addr, length, chan_mask and reverse.
  - It also selects the lowest set mask bit as the first channel.
  - If length=0 or chan_mask=0, go to DONE; valid never rises.
  - Otherwise go to RUN with valid=1, addr=start_addr, chan=first channel, all visible in cycle t+1.
- RUN:
  - A beat transfers on a rising edge with valid&&ready.
  - While valid=1 and ready=0, addr, chan and last hold stable.
  - After a transfer, the pixel index advances.
  - Address arithmetic is addr=start_addr±index modulo 2^ADDR_W: wrap-around is legal, 8'hFF+1=8'h00 and 8'h00-1=8'hFF.
  - When index reaches length-1 and that beat transfers, index resets to 0, addr resets to start_addr, and chan moves to the next higher set mask bit, skipping disabled channels.
  - last=1 exactly on the beat with index=length-1 of the highest enabled channel.
  - A transfer of that beat moves to DONE with valid=0.
  - There are no bubbles: with ready held at 1, one beat per cycle; total beats = length × popcount(chan_mask).
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- trigger while busy: ignored; latched values unchanged.
- trigger in the same cycle DONE→IDLE: ignored; it must arrive in IDLE.
- abort=1 in RUN or DONE: next state IDLE, valid=0, done=0, busy=0. Abort has priority over a simultaneous transfer.
- abort in IDLE with trigger: abort wins; the trigger is dropped.
- reset low mid-frame: immediate return to reset values; no done pulse.
- Changes to the inputs start_addr, length, chan_mask and reverse while busy have no effect.

Decomposition:
- Package send_pkg:
  - state enum type send_state_t {IDLE, RUN, DONE};
  - a function first_set(mask, from), returning the lowest set bit index ≥ from plus a found flag.
- One sub-module, send_addr_gen, is natural. It holds the index counter, the up/down modulo address and the last-pixel compare.
- send_seq keeps the FSM, the channel walk and the handshake.

Test Plan:
- Basic walk:
  - Stimulus: ADDR_W=8, CHANNELS=4, start=5, length=3, mask=4'b0001, reverse=0, ready=1.
  - Response: addr 5,6,7 on chan 0 in cycles t+1..t+3; last on addr 7; done at t+4; busy t+1..t+4.
- Masked channels with backpressure:
  - Stimulus: start=0, length=2, mask=4'b1010, ready toggling 0/1.
  - Response: beats (0,ch1),(1,ch1),(0,ch3),(1,ch3); addr/chan stable while ready=0; last only on (1,ch3).
- Reverse with wrap:
  - Stimulus: start=1, length=4, mask=4'b0001, reverse=1.
  - Response: addr 1,0,255,254; then done.
- Empty frame:
  - Stimulus: length=0, mask=4'b1111, trigger.
  - Response: valid stays 0; done pulses at t+1; idle at t+2.
  - Repeat with length=4, mask=0 and require the same response.
- Abort and retrigger:
  - Stimulus: length=10, mask=4'b0001; abort after 3 beats; trigger during RUN.
  - Response: the trigger during RUN is ignored; after abort, valid=0 next cycle with no done pulse.
  - A new trigger with start=20 then restarts at addr 20.
- Async reset:
  - Stimulus: reset low mid-beat, between clock edges.
  - Response: valid, busy and done drop without waiting for a clock edge; addr=0.

Source files
------------

// File: rtl/send_pkg.sv
// rtl/send_pkg.sv - shared types and helpers for the pixel address sender
// Contents:
//   send_state_t  FSM state encoding (IDLE, RUN, DONE)
//   first_set_t   result of first_set: found flag plus bit index
//   first_set()   lowest set mask bit at or above a starting index
package send_pkg;

  // Widest channel mask the helper understands; callers zero-extend to this.
  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } send_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } first_set_t;

  // Scan from the top down so the last hit written is the lowest qualifying bit.
  function automatic first_set_t first_set(input logic [MAX_CH-1:0] mask,
                                           input logic [4:0]        from);
    first_set_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/send_addr_gen.sv
// rtl/send_addr_gen.sv - pixel index counter, up/down modulo address, last-pixel compare
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            capture start_addr/length/reverse and restart the walk
//   step            one beat transferred; advance (or rewind after the last pixel)
//   start_addr      first pixel address
//   length          pixels per channel
//   reverse         walk downwards when set
//   addr            current pixel address
//   at_last         current index is length-1
module send_addr_gen
  import send_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              reverse,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] len_q;
  logic              rev_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;

  // len_q is never 0 while beats are being stepped, so the wrap of len_q-1 is harmless.
  assign at_last = (idx_q == (len_q - ADDR_W'(1)));
  assign addr    = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= '0;
      len_q   <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else if (load) begin
      start_q <= start_addr;
      len_q   <= length;
      rev_q   <= reverse;
      idx_q   <= '0;
      addr_q  <= start_addr;
    end else if (step) begin
      if (at_last) begin
        // Next channel starts the same window again.
        idx_q  <= '0;
        addr_q <= start_q;
      end else begin
        idx_q  <= idx_q + ADDR_W'(1);
        // Natural modulo-2^ADDR_W wrap in both directions.
        addr_q <= rev_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
      end
    end
  end

endmodule

// File: rtl/send_seq.sv
// rtl/send_seq.sv - multi-channel pixel address sequencer with valid/ready output
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start_addr      first pixel address (sampled on accepted trigger)
//   length          pixels per channel, 0 = empty frame
//   chan_mask       channel enable mask (sampled on accepted trigger)
//   reverse         walk addresses downwards (sampled on accepted trigger)
//   trigger         one-cycle start request, honoured only in IDLE
//   abort           synchronous cancel, beats trigger and transfer
//   addr, chan      current beat
//   valid, ready    beat handshake
//   last            final beat of the frame
//   busy            high in RUN and DONE
//   done            one-cycle completion pulse
module send_seq
  import send_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic                reverse,
  input  logic                trigger,
  input  logic                abort,
  output logic [ADDR_W-1:0]   addr,
  output logic [CH_W-1:0]     chan,
  output logic                valid,
  input  logic                ready,
  output logic                last,
  output logic                busy,
  output logic                done
);

  send_state_t       state;
  logic [CH_W-1:0]   chan_q;
  logic [MAX_CH-1:0] mask_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic [MAX_CH-1:0] mask_in_ext;
  first_set_t        first_fs;
  first_set_t        next_fs;
  logic              load;
  logic              step;
  logic              at_last;

  always_comb begin
    mask_in_ext                 = '0;
    mask_in_ext[CHANNELS-1:0]   = chan_mask;
  end

  assign first_fs = first_set(mask_in_ext, 5'd0);
  // Next enabled channel above the current one; not found means this is the top channel.
  assign next_fs  = first_set(mask_q, 5'(chan_q) + 5'd1);

  assign load = (state == IDLE) && trigger && !abort;
  assign step = (state == RUN) && valid_q && ready && !abort;

  send_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .start_addr (start_addr),
    .length     (length),
    .reverse    (reverse),
    .addr       (addr),
    .at_last    (at_last)
  );

  assign chan  = chan_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  // Derived only from registered state, so it is stable while ready is low.
  assign last  = valid_q && at_last && !next_fs.found;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      chan_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            mask_q <= mask_in_ext;
            busy_q <= 1'b1;
            if ((length == '0) || !first_fs.found) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state   <= RUN;
              valid_q <= 1'b1;
              chan_q  <= CH_W'(first_fs.idx);
            end
          end
        end

        RUN: begin
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (step && at_last) begin
            if (next_fs.found) begin
              chan_q <= CH_W'(next_fs.idx);
            end else begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        DONE: begin
          // Abort and normal exit both land in IDLE with everything low.
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_seq.sv
// tb/tb_send_seq.sv - directed self-checking bench for send_seq
module tb_send_seq;

  logic       clk;
  logic       reset;
  logic [7:0] start_addr;
  logic [7:0] length;
  logic [3:0] chan_mask;
  logic       reverse;
  logic       trigger;
  logic       abort;
  logic [7:0] addr;
  logic [1:0] chan;
  logic       valid;
  logic       ready;
  logic       last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  send_seq #(
    .ADDR_W   (8),
    .CHANNELS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_addr (start_addr),
    .length     (length),
    .chan_mask  (chan_mask),
    .reverse    (reverse),
    .trigger    (trigger),
    .abort      (abort),
    .addr       (addr),
    .chan       (chan),
    .valid      (valid),
    .ready      (ready),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one visible beat: valid, addr, chan, last.
  task automatic beat(input string tag, input logic [7:0] a, input logic [1:0] c,
                      input logic l);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_addr"},  32'(addr),  32'(a));
    chk({tag, "_chan"},  32'(chan),  32'(c));
    chk({tag, "_last"},  32'(last),  32'(l));
  endtask

  initial begin
    reset      = 1'b0;
    start_addr = '0;
    length     = '0;
    chan_mask  = '0;
    reverse    = 1'b0;
    trigger    = 1'b0;
    abort      = 1'b0;
    ready      = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_addr",  32'(addr),  32'd0);
    chk("rst_chan",  32'(chan),  32'd0);
    chk("rst_last",  32'(last),  32'd0);
    reset = 1'b1;
    tick();

    // Basic walk: 5,6,7 on channel 0.
    start_addr = 8'd5; length = 8'd3; chan_mask = 4'b0001; reverse = 1'b0;
    ready = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    start_addr = 8'd99;  // must not disturb the running frame
    beat("b1_0", 8'd5, 2'd0, 1'b0);
    chk("b1_busy1", 32'(busy), 32'd1);
    chk("b1_done1", 32'(done), 32'd0);
    tick();
    beat("b1_1", 8'd6, 2'd0, 1'b0);
    tick();
    beat("b1_2", 8'd7, 2'd0, 1'b1);
    tick();
    chk("b1_dvalid", 32'(valid), 32'd0);
    chk("b1_done",   32'(done),  32'd1);
    chk("b1_dbusy",  32'(busy),  32'd1);
    trigger = 1'b1;  // lands on the DONE->IDLE edge, must be dropped
    tick();
    trigger = 1'b0;
    chk("b1_idone", 32'(done), 32'd0);
    chk("b1_ibusy", 32'(busy), 32'd0);
    tick();
    chk("b1_nostart", 32'(valid), 32'd0);

    // Masked channels 1 and 3 with backpressure.
    start_addr = 8'd0; length = 8'd2; chan_mask = 4'b1010; ready = 1'b0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    beat("m_a", 8'd0, 2'd1, 1'b0);
    tick();
    beat("m_a_hold", 8'd0, 2'd1, 1'b0);
    ready = 1'b1;
    tick();
    beat("m_b", 8'd1, 2'd1, 1'b0);
    ready = 1'b0;
    tick();
    beat("m_b_hold", 8'd1, 2'd1, 1'b0);
    ready = 1'b1;
    tick();
    beat("m_c", 8'd0, 2'd3, 1'b0);
    ready = 1'b0;
    tick();
    beat("m_c_hold", 8'd0, 2'd3, 1'b0);
    ready = 1'b1;
    tick();
    beat("m_d", 8'd1, 2'd3, 1'b1);
    ready = 1'b0;
    tick();
    beat("m_d_hold", 8'd1, 2'd3, 1'b1);
    ready = 1'b1;
    tick();
    chk("m_done",  32'(done),  32'd1);
    chk("m_valid", 32'(valid), 32'd0);
    tick();

    // Reverse walk with wrap below zero.
    start_addr = 8'd1; length = 8'd4; chan_mask = 4'b0001; reverse = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    beat("r_0", 8'd1,   2'd0, 1'b0);
    tick();
    beat("r_1", 8'd0,   2'd0, 1'b0);
    tick();
    beat("r_2", 8'hFF, 2'd0, 1'b0);
    tick();
    beat("r_3", 8'hFE, 2'd0, 1'b1);
    tick();
    chk("r_done", 32'(done), 32'd1);
    tick();
    reverse = 1'b0;

    // Empty frame: length 0.
    length = 8'd0; chan_mask = 4'b1111; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("e0_valid", 32'(valid), 32'd0);
    chk("e0_done",  32'(done),  32'd1);
    chk("e0_busy",  32'(busy),  32'd1);
    tick();
    chk("e0_idone", 32'(done), 32'd0);
    chk("e0_ibusy", 32'(busy), 32'd0);

    // Empty frame: mask 0.
    length = 8'd4; chan_mask = 4'b0000; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("em_valid", 32'(valid), 32'd0);
    chk("em_done",  32'(done),  32'd1);
    tick();
    chk("em_idone", 32'(done),  32'd0);
    chk("em_ivalid", 32'(valid), 32'd0);

    // Abort and retrigger.
    start_addr = 8'd0; length = 8'd10; chan_mask = 4'b0001; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    beat("a_0", 8'd0, 2'd0, 1'b0);
    start_addr = 8'd50; trigger = 1'b1;  // ignored while busy
    tick();
    trigger = 1'b0;
    beat("a_1", 8'd1, 2'd0, 1'b0);
    tick();
    beat("a_2", 8'd2, 2'd0, 1'b0);
    tick();
    beat("a_3", 8'd3, 2'd0, 1'b0);
    abort = 1'b1;  // together with ready=1: abort wins
    tick();
    abort = 1'b0;
    chk("a_valid", 32'(valid), 32'd0);
    chk("a_busy",  32'(busy),  32'd0);
    chk("a_done",  32'(done),  32'd0);
    tick();
    chk("a_done2", 32'(done), 32'd0);
    abort = 1'b1; trigger = 1'b1;  // abort beats trigger in IDLE
    tick();
    abort = 1'b0; trigger = 1'b0;
    chk("ai_valid", 32'(valid), 32'd0);
    chk("ai_busy",  32'(busy),  32'd0);
    start_addr = 8'd20; length = 8'd2; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    beat("rt_0", 8'd20, 2'd0, 1'b0);
    tick();
    beat("rt_1", 8'd21, 2'd0, 1'b1);
    tick();
    chk("rt_done", 32'(done), 32'd1);
    tick();

    // Asynchronous reset between edges.
    start_addr = 8'd40; length = 8'd10; chan_mask = 4'b0100; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    beat("ar_pre", 8'd41, 2'd2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_busy",  32'(busy),  32'd0);
    chk("ar_done",  32'(done),  32'd0);
    chk("ar_addr",  32'(addr),  32'd0);
    chk("ar_chan",  32'(chan),  32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_after", 32'(valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
